// File: rtl/ca5_tx_pkg.sv
// Shared types and constants for the ca5 serial frame transmitter.
// Frames are a fixed flag, an LSB-first length count, then LSB-first payload bits.
package ca5_tx_pkg;

   localparam int unsigned MAX_PAYLOAD_DEF = 32;
   localparam int unsigned LEN_W_DEF       = 8;
   localparam int unsigned FLAG_LEN        = 7;

   // Bit 0 goes on the wire first: 0,1,1,1,1,1,0.
   localparam logic [FLAG_LEN-1:0] FLAG = 7'b0111110;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLAG,
      ST_LEN,
      ST_PAYLOAD
   } tx_state_e;

   function automatic int unsigned clamp_len(input int unsigned req, input int unsigned lim);
      return (req > lim) ? lim : req;
   endfunction

endpackage

// File: rtl/ca5_piso.sv
// Parallel-load, LSB-first shift register; dout is always the current bit 0.
// Load takes priority over shift.
module ca5_piso #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         dout
);

   logic [W-1:0] sh_q, sh_d;

   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = din;
      end else if (shift) begin
         sh_d = sh_q >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign dout = sh_q[0];

endmodule

// File: rtl/ca5_qe_tx.sv
// Serial frame transmitter: flag, length count and payload, one bit per clk.
// Every output is a flop; the FSM state names the field currently on the wire.
module ca5_qe_tx
   import ca5_tx_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEF,
   parameter int unsigned LEN_W       = LEN_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [5:0]             len,
   input  logic [MAX_PAYLOAD-1:0] data,
   output logic                   ready,
   output logic                   serout,
   output logic                   seroutvalid,
   output logic                   done
);

   localparam int unsigned SH_W    = (MAX_PAYLOAD > LEN_W) ? MAX_PAYLOAD : LEN_W;
   localparam int unsigned CNT_MAX = (SH_W > FLAG_LEN) ? SH_W : FLAG_LEN;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   tx_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic [MAX_PAYLOAD-1:0] data_q, data_d;
   logic                   serout_q, serout_d;
   logic                   valid_q, valid_d;
   logic                   done_q, done_d;
   logic                   ready_q, ready_d;

   logic                   piso_load, piso_shift, piso_dout;
   logic [SH_W-1:0]        piso_din;
   logic [FLAG_LEN-1:0]    flag_sh;

   ca5_piso #(.W(SH_W)) u_piso (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (piso_load),
      .shift (piso_shift),
      .din   (piso_din),
      .dout  (piso_dout)
   );

   // The first bit of each field is driven straight from the latched value while
   // the shifter is loaded with the remainder, so fields abut with no gap cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      data_d     = data_q;
      serout_d   = 1'b0;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      ready_d    = 1'b0;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
      piso_din   = '0;
      flag_sh    = FLAG >> (cnt_q[2:0] + 3'd1);

      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            if (start) begin
               state_d  = ST_FLAG;
               cnt_d    = '0;
               len_d    = LEN_W'(clamp_len(32'(len), MAX_PAYLOAD));
               data_d   = data;
               serout_d = FLAG[0];
               valid_d  = 1'b1;
               ready_d  = 1'b0;
            end
         end

         ST_FLAG: begin
            valid_d = 1'b1;
            if (cnt_q == CNT_W'(FLAG_LEN - 1)) begin
               state_d   = ST_LEN;
               cnt_d     = '0;
               serout_d  = len_q[0];
               piso_load = 1'b1;
               piso_din  = SH_W'(len_q) >> 1;
            end else begin
               cnt_d    = cnt_q + 1'b1;
               serout_d = flag_sh[0];
            end
         end

         ST_LEN: begin
            if (cnt_q == CNT_W'(LEN_W - 1)) begin
               cnt_d = '0;
               if (len_q != '0) begin
                  state_d   = ST_PAYLOAD;
                  serout_d  = data_q[0];
                  valid_d   = 1'b1;
                  piso_load = 1'b1;
                  piso_din  = SH_W'(data_q) >> 1;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
               end
            end else begin
               cnt_d      = cnt_q + 1'b1;
               serout_d   = piso_dout;
               valid_d    = 1'b1;
               piso_shift = 1'b1;
            end
         end

         ST_PAYLOAD: begin
            if (32'(cnt_q) + 32'd1 == 32'(len_q)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               ready_d = 1'b1;
            end else begin
               cnt_d      = cnt_q + 1'b1;
               serout_d   = piso_dout;
               valid_d    = 1'b1;
               piso_shift = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         data_q   <= '0;
         serout_q <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         data_q   <= data_d;
         serout_q <= serout_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
      end
   end

   assign ready       = ready_q;
   assign serout      = serout_q;
   assign seroutvalid = valid_q;
   assign done        = done_q;

endmodule

// File: tb/tb_ca5_qe_tx.sv
// Bench for ca5_qe_tx: directed scenarios then random traffic, compared cycle by
// cycle against a queue of expected {ready,serout,seroutvalid,done} values.
module tb_ca5_qe_tx;

   localparam int unsigned MAXP = 32;
   localparam int unsigned LW   = 8;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [5:0]      len   = '0;
   logic [MAXP-1:0] data  = '0;
   logic            ready, serout, seroutvalid, done;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   // Expected outputs per cycle, packed as {ready, serout, seroutvalid, done}.
   logic [3:0] exp_q[$];
   int         flag_bits[7] = '{0, 1, 1, 1, 1, 1, 0};

   ca5_qe_tx #(.MAX_PAYLOAD(MAXP), .LEN_W(LW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .len         (len),
      .data        (data),
      .ready       (ready),
      .serout      (serout),
      .seroutvalid (seroutvalid),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got[3:0], exp[3:0], $time);
   endtask

   function automatic void push_frame(input int unsigned l, input logic [MAXP-1:0] d);
      int unsigned n;
      n = (l > MAXP) ? MAXP : l;
      for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 1'(flag_bits[i]), 1'b1, 1'b0});
      for (int i = 0; i < int'(LW); i++) exp_q.push_back({1'b0, 1'((n >> i) & 1), 1'b1, 1'b0});
      for (int i = 0; i < int'(n); i++) exp_q.push_back({1'b0, d[i], 1'b1, 1'b0});
      exp_q.push_back(4'b1001);
   endfunction

   // Reference acceptance: a start is taken only when no frame or done is pending.
   always @(posedge clk) begin
      if (!rst_n) exp_q.delete();
      else if (exp_q.size() == 0 && start) push_frame(len, data);
   end

   task automatic step(input logic s, input int unsigned l, input logic [MAXP-1:0] d,
                       input string tag);
      logic [3:0] exp;
      @(negedge clk);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b1000;
      check_eq(tag, {60'd0, ready, serout, seroutvalid, done}, {60'd0, exp});
      start = s;
      len   = 6'(l);
      data  = d;
   endtask

   task automatic pulse_reset(input string tag);
      #2;
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check_eq(tag, {60'd0, ready, serout, seroutvalid, done}, 64'b1000);
      exp_q.delete();
      repeat (2) step(1'b0, 0, '0, tag);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [MAXP-1:0] r;
      repeat (3) step(1'b0, 0, '0, "reset");
      rst_n = 1'b1;
      step(1'b0, 0, '0, "idle");

      step(1'b1, 5, 32'h15, "len5");
      repeat (25) step(1'b0, 5, 32'h15, "len5");

      step(1'b1, 0, 32'hDEADBEEF, "len0");
      repeat (18) step(1'b0, 0, 32'hDEADBEEF, "len0");

      step(1'b1, 40, '1, "clamp");
      repeat (52) step(1'b0, 40, '1, "clamp");

      repeat (20) step(1'b1, 3, 32'h3, "b2b");
      repeat (22) step(1'b0, 3, 32'h3, "b2b");

      r = $urandom;
      step(1'b1, 20, r, "midstart");
      repeat (20) step(1'b0, 20, r, "midstart");
      step(1'b1, 7, ~r, "midstart");
      step(1'b0, 9, 32'h0, "midstart");
      repeat (30) step(1'b0, 9, 32'h0, "midstart");

      r = $urandom;
      step(1'b1, 12, r, "abort");
      repeat (10) step(1'b0, 12, r, "abort");
      pulse_reset("abort_rst");
      r = $urandom;
      step(1'b1, 4, r, "after_rst");
      repeat (25) step(1'b0, 4, r, "after_rst");

      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 199) == 0) pulse_reset("rand_rst");
         else step($urandom_range(0, 3) == 0, $urandom_range(0, 63), $urandom, "rand");
      end
      repeat (60) step(1'b0, 0, '0, "drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ca5_qe_tx.md
CA5_QE_TX -- requirements
Module: ca5_qe_tx

Interface
REQ-001 Parameters SHALL be: MAX_PAYLOAD, default 32, maximum payload bits per frame; LEN_W, default 8, width of the on-wire length field.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to send one frame
- len  in  6  requested payload bit count
- data  in  MAX_PAYLOAD  payload; bit 0 is sent first
- ready  out  1  idle, able to accept start
- serout  out  1  serial line
- seroutvalid  out  1  high while a frame bit is on serout
- done  out  1  one-cycle pulse after the last frame bit
REQ-003 The clock SHALL be a single clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-004 Frame format SHALL be: 7-bit flag, sent in order 0,1,1,1,1,1,0; then LEN_W-bit payload count, LSB first; then that many payload bits, data[0] first. This is the framing that ca5_qd receives.
REQ-005 The FSM SHALL have four states: IDLE, FLAG, LEN and PAYLOAD.
REQ-006 In IDLE, ready SHALL be 1, serout SHALL be 0 and seroutvalid SHALL be 0.
REQ-007 A start sampled high in IDLE SHALL latch len and data and SHALL move the FSM to FLAG; ready SHALL drop in the next cycle.
REQ-008 The first flag bit SHALL appear on serout in the cycle after acceptance; every frame bit SHALL be held for exactly one clk cycle.
REQ-009 Transitions SHALL be: FLAG to LEN after 7 bits; LEN to PAYLOAD after LEN_W bits when the count is nonzero; LEN to IDLE when the count is zero; PAYLOAD to IDLE after the last payload bit.
REQ-010 seroutvalid SHALL be 1 for exactly the 7+LEN_W+N frame-bit cycles and 0 otherwise.
REQ-011 done SHALL pulse high for one cycle, coincident with the first IDLE cycle after a frame; ready SHALL be 1 in that same cycle.
REQ-012 A len above MAX_PAYLOAD SHALL be clamped to MAX_PAYLOAD; the transmitted count field SHALL equal the clamped value.
REQ-013 len = 0 SHALL produce the flag plus a zero count field (15 bits) and no payload.
REQ-014 start while not ready SHALL be ignored, with no effect on the frame in progress.
REQ-015 start held high in the done cycle SHALL be accepted, giving back-to-back frames with exactly one idle cycle between them.
REQ-016 Changes to len or data after acceptance SHALL NOT affect the frame in progress.
REQ-017 A bit counter SHALL count within each field and reset to 0 at each field transition; it SHALL never wrap within a field.
REQ-018 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-019 rst_n low SHALL immediately force: state IDLE, ready 1, serout 0, seroutvalid 0, done 0, counters and shift register 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no done pulse; transmission SHALL resume only on a new start after rst_n is released.

Structure
REQ-021 Package ca5_tx_pkg SHALL hold the state enum, the FLAG constant (7'b0111110 with transmission order stated), FLAG_LEN = 7 and the default widths.
REQ-022 Sub-module ca5_piso SHALL be the one parallel-load, LSB-first shift register, reused for the count and payload fields.

Verification
REQ-023 A bench SHALL cover these directed scenarios:
- len=5, data=...10101 -> serout 0111110 10100000 10101, seroutvalid high 20 cycles, done in cycle 21 after acceptance.
- len=0 -> serout 0111110 00000000, seroutvalid high 15 cycles, then done.
- len=40, data=32'hFFFFFFFF -> count field 00000100 (32, LSB first), then 32 ones.
- start held high across two frames (len=3, data=3'b011) -> two identical 18-bit frames separated by one idle cycle with done high.
- start pulsed mid-payload with new len and data -> current frame unchanged, no second frame.
- rst_n low at bit 10 of a frame -> serout, seroutvalid and done go 0 immediately, ready goes 1; the next start sends a complete frame.
